pipewbarb: RTL

PIPEWBARB -- requirements
Module: pipewbarb

---
 rtl/pipewbarb.sv | 81 ++++++++
 1 files changed

// File: rtl/pipewbarb.sv
// pipewbarb: WB/MDU register-file write-port arbiter with 2-entry MDU FIFO; WBARB_BYPASS_EN adds an empty-FIFO bypass
module pipewbarb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wwreg,
    input  logic        wm2reg,
    input  logic [31:0] wmo,
    input  logic [31:0] walu,
    input  logic [4:0]  wrn,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rn,
    input  logic [31:0] mdu_res,
    output logic        mdu_ready,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        pend_hit,
    output logic        bubble_req,
    output logic        rf_we,
    output logic [4:0]  rf_wn,
    output logic [31:0] rf_d
);
    typedef enum logic {IDLE, REQ} state_t;
    state_t      state_q, state_d;
    logic [1:0]  count_q, count_d;
    logic        wp_q, wp_d, rp_q, rp_d;
    logic [4:0]  rn_q[2], rn_d[2];
    logic [31:0] res_q[2], res_d[2];
    logic [3:0]  starve_q, starve_d;
    logic        pop, push, bypass, v0, v1;
    always_comb begin
        mdu_ready = count_q < 2'd2;
`ifdef WBARB_BYPASS_EN
        bypass = !reset && count_q == 2'd0 && !wwreg && mdu_valid && mdu_rn != 5'd0;
`else
        bypass = 1'b0;
`endif
        // reset silences FIFO pops so the port stays quiet while state is being cleared
        pop = !reset && !wwreg && count_q != 2'd0;
        push = mdu_valid && mdu_ready && mdu_rn != 5'd0 && !bypass;
        rf_we = wwreg || pop || bypass;
        rf_wn = wwreg ? wrn : pop ? rn_q[rp_q] : bypass ? mdu_rn : 5'd0;
        rf_d = wwreg ? (wm2reg ? wmo : walu) : pop ? res_q[rp_q] : bypass ? mdu_res : 32'd0;
        v0 = count_q == 2'd2 || (count_q == 2'd1 && !rp_q);
        v1 = count_q == 2'd2 || (count_q == 2'd1 && rp_q);
        pend_hit = (v0 && ((rs != 5'd0 && rn_q[0] == rs) || (rt != 5'd0 && rn_q[0] == rt)))
                || (v1 && ((rs != 5'd0 && rn_q[1] == rs) || (rt != 5'd0 && rn_q[1] == rt)));
        rn_d = rn_q;
        res_d = res_q;
        if (push) begin
            rn_d[wp_q] = mdu_rn;
            res_d[wp_q] = mdu_res;
        end
        wp_d = wp_q ^ push;
        rp_d = rp_q ^ pop;
        count_d = count_q + 2'(push) - 2'(pop);
        starve_d = (count_q == 2'd0 || pop) ? 4'd0 : (starve_q == 4'hf ? starve_q : starve_q + 4'd1);
        state_d = state_q == IDLE ? (starve_d >= 4'(STARVE_LIMIT) ? REQ : IDLE) : (pop ? IDLE : REQ);
        bubble_req = state_q == REQ;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= 2'd0;
            wp_q <= 1'b0;
            rp_q <= 1'b0;
            starve_q <= 4'd0;
            state_q <= IDLE;
        end else begin
            count_q <= count_d;
            wp_q <= wp_d;
            rp_q <= rp_d;
            starve_q <= starve_d;
            state_q <= state_d;
        end
    end
    always_ff @(posedge clock) begin
        rn_q <= rn_d;
        res_q <= res_d;
    end
endmodule
